// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit
// Memory-stage load/store unit for the MIPS pipeline. It takes the M-stage
// address, store data and memory-op code, runs one access on a
// request / address-ok / data-ok data bus, and returns sign- or zero-extended
// load data for writeback. Misaligned halfword/word accesses raise an address
// error instead of touching the bus. The pipeline is stalled while an access
// is outstanding.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   memenM, memopM, addrM    M-stage memory enable, op code, byte address
//   writedataM, flushM       store source value, M-stage cancel (IDLE only)
//   stall_o                  freeze F..M pipeline registers
//   readdataM                extended load data, valid in DONE
//   adelM, adesM, badaddrM   load/store address error and faulting address
//   bus_err                  one-cycle pulse in DONE after a bus timeout
//   data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
//                            registered bus request fields
//   data_addr_ok, data_rdata, data_data_ok
//                            bus responses
module load_store_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic [2:0]  memopM,
  input  logic [31:0] addrM,
  input  logic [31:0] writedataM,
  input  logic        flushM,
  output logic        stall_o,
  output logic [31:0] readdataM,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] badaddrM,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  // The counter only has to reach MAX_WAIT-1; the access leaves REQ/WAIT
  // on that cycle.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsuStateT;

  lsuStateT      state, nextState;

  logic [CW-1:0] waitCnt;
  logic [2:0]    opReg;
  logic [31:0]   addrReg;
  logic          wrReg;
  logic [1:0]    sizeReg;
  logic [3:0]    wstrbReg;
  logic [31:0]   wdataReg;
  logic [31:0]   rdataReg;
  logic          timedOut;
  logic          reqReg;

  logic          isStoreM;
  logic [1:0]    sizeM;
  logic          misalignM;
  logic          accessErr;
  logic          startAccess;
  logic [3:0]    wstrbM;
  logic [31:0]   wdataM;

  logic          lastBusCycle;
  logic          busDone;
  logic          busTimeout;

  logic [7:0]    loadByte;
  logic [15:0]   loadHalf;
  logic [31:0]   loadData;

  // Decode the incoming M-stage op: access size, alignment check, whether
  // a new access starts this cycle, and the lane-replicated store data.
  // A flushed instruction neither faults nor starts an access.
  always_comb begin
    isStoreM = memopM[2] & (memopM[1] | memopM[0]);
    case (memopM)
      3'b000, 3'b001, 3'b101: sizeM = 2'd0;
      3'b010, 3'b011, 3'b110: sizeM = 2'd1;
      default:                sizeM = 2'd2;
    endcase
    misalignM   = ((sizeM == 2'd1) && addrM[0]) ||
                  ((sizeM == 2'd2) && (addrM[1:0] != 2'b00));
    accessErr   = (state == IDLE) && memenM && !flushM && misalignM;
    startAccess = (state == IDLE) && memenM && !flushM && !misalignM;
    wstrbM      = 4'b0000;
    wdataM      = 32'h0;
    if (isStoreM) begin
      case (sizeM)
        2'd0: begin
          wstrbM = 4'b0001 << addrM[1:0];
          wdataM = {4{writedataM[7:0]}};
        end
        2'd1: begin
          wstrbM = addrM[1] ? 4'b1100 : 4'b0011;
          wdataM = {2{writedataM[15:0]}};
        end
        default: begin
          wstrbM = 4'b1111;
          wdataM = writedataM;
        end
      endcase
    end
  end

  // Bus completion and timeout. A response arriving in the last allowed
  // cycle still counts as a normal completion.
  always_comb begin
    lastBusCycle = (waitCnt == CW'(MAX_WAIT - 1));
    busDone      = ((state == REQ) && data_addr_ok && data_data_ok) ||
                   ((state == WAIT) && data_data_ok);
    busTimeout   = ((state == REQ) || (state == WAIT)) && !busDone && lastBusCycle;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic. DONE always returns to IDLE so back-to-back ops never
  // overlap on the bus.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startAccess) nextState = REQ;
      REQ: begin
        if (busDone || busTimeout) nextState = DONE;
        else if (data_addr_ok)     nextState = WAIT;
      end
      WAIT: if (busDone || busTimeout) nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Access datapath: latch the request fields at launch so they stay stable
  // through REQ, count bus cycles, and capture load data on completion.
  // data_req is registered from the next state so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt  <= '0;
      opReg    <= 3'b000;
      addrReg  <= 32'h0;
      wrReg    <= 1'b0;
      sizeReg  <= 2'd0;
      wstrbReg <= 4'b0000;
      wdataReg <= 32'h0;
      rdataReg <= 32'h0;
      timedOut <= 1'b0;
      reqReg   <= 1'b0;
    end else begin
      reqReg <= (nextState == REQ);
      case (state)
        IDLE: begin
          if (startAccess) begin
            waitCnt  <= '0;
            opReg    <= memopM;
            addrReg  <= addrM;
            wrReg    <= isStoreM;
            sizeReg  <= sizeM;
            wstrbReg <= wstrbM;
            wdataReg <= wdataM;
            rdataReg <= 32'h0;
            timedOut <= 1'b0;
          end
        end
        REQ, WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (busDone && !wrReg) rdataReg <= data_rdata;
          if (busTimeout)        timedOut <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pick the addressed byte/half out of the captured word and extend it.
  always_comb begin
    case (addrReg[1:0])
      2'd0:    loadByte = rdataReg[7:0];
      2'd1:    loadByte = rdataReg[15:8];
      2'd2:    loadByte = rdataReg[23:16];
      default: loadByte = rdataReg[31:24];
    endcase
    loadHalf = addrReg[1] ? rdataReg[31:16] : rdataReg[15:0];
    case (opReg)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {24'h0, loadByte};
      3'b010:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b011:  loadData = {16'h0, loadHalf};
      default: loadData = rdataReg;
    endcase
  end

  // FSM outputs. The stall covers the launch cycle in IDLE plus every bus
  // cycle; a timed-out access returns zero data.
  always_comb begin
    stall_o   = startAccess || (state == REQ) || (state == WAIT);
    adelM     = accessErr && !isStoreM;
    adesM     = accessErr && isStoreM;
    badaddrM  = accessErr ? addrM : 32'h0;
    bus_err   = (state == DONE) && timedOut;
    readdataM = ((state == DONE) && !timedOut) ? loadData : 32'h0;
  end

  assign data_req   = reqReg;
  assign data_wr    = wrReg;
  assign data_size  = sizeReg;
  assign data_addr  = addrReg;
  assign data_wstrb = wstrbReg;
  assign data_wdata = wdataReg;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// tb_load_store_unit
// Table-driven bench for load_store_unit plus hand-written sequences for
// bus wait states, timeout and reset in the middle of an access. A second
// instance with MAX_WAIT=4 handles the timeout and mid-access reset cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memenM = 1'b0;
  logic        memenTo = 1'b0;
  logic [2:0]  memopM = 3'b000;
  logic [31:0] addrM = 32'h0;
  logic [31:0] writedataM = 32'h0;
  logic        flushM = 1'b0;
  logic        dataAddrOk = 1'b0;
  logic [31:0] dataRdata = 32'h0;
  logic        dataDataOk = 1'b0;

  logic        stallO, adel, ades, busErr, dataReq, dataWr;
  logic [31:0] readData, badAddr, dataAddr, dataWdata;
  logic [1:0]  dataSize;
  logic [3:0]  dataWstrb;

  logic        stallTo, adelTo, adesTo, busErrTo, reqTo, wrTo;
  logic [31:0] readTo, badAddrTo, addrTo, wdataTo;
  logic [1:0]  sizeTo;
  logic [3:0]  wstrbTo;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LHU = 3'b011,
                         LW = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  load_store_unit dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memopM(memopM), .addrM(addrM),
    .writedataM(writedataM), .flushM(flushM), .stall_o(stallO),
    .readdataM(readData), .adelM(adel), .adesM(ades), .badaddrM(badAddr),
    .bus_err(busErr), .data_req(dataReq), .data_wr(dataWr),
    .data_size(dataSize), .data_addr(dataAddr), .data_wstrb(dataWstrb),
    .data_wdata(dataWdata), .data_addr_ok(dataAddrOk), .data_rdata(dataRdata),
    .data_data_ok(dataDataOk)
  );

  load_store_unit #(.MAX_WAIT(4)) dutTo (
    .clk(clk), .rst(rst), .memenM(memenTo), .memopM(memopM), .addrM(addrM),
    .writedataM(writedataM), .flushM(flushM), .stall_o(stallTo),
    .readdataM(readTo), .adelM(adelTo), .adesM(adesTo), .badaddrM(badAddrTo),
    .bus_err(busErrTo), .data_req(reqTo), .data_wr(wrTo),
    .data_size(sizeTo), .data_addr(addrTo), .data_wstrb(wstrbTo),
    .data_wdata(wdataTo), .data_addr_ok(dataAddrOk), .data_rdata(dataRdata),
    .data_data_ok(dataDataOk)
  );

  always #5 clk = ~clk;

  // Single-access vector: inputs and the expected bus fields / results.
  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        expAdel;
    logic        expAdes;
    logic        expWr;
    logic [1:0]  expSize;
    logic [3:0]  expWstrb;
    logic [31:0] expWdata;
    logic [31:0] expRead;
  } vecT;

  localparam int NV = 17;
  vecT vecs[NV];

  task automatic applyStimulus(input logic men, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic aok, input logic dok,
                               input logic [31:0] rd, input logic fl);
    memenM     = men;
    memopM     = op;
    addrM      = addr;
    writedataM = wd;
    dataAddrOk = aok;
    dataDataOk = dok;
    dataRdata  = rd;
    flushM     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Safety net so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          op   addr          wd            rd            adel  ades  wr    size  wstrb    wdata         read
    vecs[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{LH,  32'h102, 32'h0,        32'h80011234, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{LHU, 32'h102, 32'h0,        32'h80011234, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h00008001};
    vecs[5]  = '{LB,  32'h101, 32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h00000056};
    vecs[6]  = '{LH,  32'h100, 32'h0,        32'h0000F00F, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,        32'hFFFFF00F};
    vecs[7]  = '{LBU, 32'h107, 32'h0,        32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h000000A1};
    vecs[8]  = '{SB,  32'h201, 32'h000000AB, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 32'hABABABAB, 32'h0};
    vecs[9]  = '{SH,  32'h202, 32'h00001234, 32'h0,        1'b0, 1'b0, 1'b1, 2'd1, 4'b1100, 32'h12341234, 32'h0};
    vecs[10] = '{SW,  32'h204, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{SH,  32'h200, 32'h00005678, 32'h0,        1'b0, 1'b0, 1'b1, 2'd1, 4'b0011, 32'h56785678, 32'h0};
    vecs[12] = '{SB,  32'h203, 32'hFFFFFF12, 32'h0,        1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 32'h12121212, 32'h0};
    vecs[13] = '{LW,  32'h102, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0};
    vecs[14] = '{SH,  32'h301, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0};
    vecs[15] = '{SW,  32'h302, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0};
    vecs[16] = '{LHU, 32'h103, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h0};

    // Reset state with idle inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset stall", 32'(stallO), 32'h0);
    checkOutput("reset readdata", readData, 32'h0);
    checkOutput("reset badaddr", badAddr, 32'h0);
    checkOutput("reset data_req", 32'(dataReq), 32'h0);
    checkOutput("reset data_addr", dataAddr, 32'h0);
    checkOutput("reset data_wstrb", 32'(dataWstrb), 32'h0);
    checkOutput("reset data_wdata", dataWdata, 32'h0);
    checkOutput("reset bus_err", 32'(busErr), 32'h0);
    rst = 1'b0;

    // Table: one access per vector, bus answers in the first REQ cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i].op, vecs[i].addr, vecs[i].wd, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      if (vecs[i].expAdel || vecs[i].expAdes) begin
        checkOutput($sformatf("v%0d adelM", i), 32'(adel), 32'(vecs[i].expAdel));
        checkOutput($sformatf("v%0d adesM", i), 32'(ades), 32'(vecs[i].expAdes));
        checkOutput($sformatf("v%0d badaddrM", i), badAddr, vecs[i].addr);
        checkOutput($sformatf("v%0d err stall", i), 32'(stallO), 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput($sformatf("v%0d err no data_req", i), 32'(dataReq), 32'h0);
      end else begin
        checkOutput($sformatf("v%0d idle stall", i), 32'(stallO), 32'h1);
        checkOutput($sformatf("v%0d no adel", i), 32'(adel), 32'h0);
        checkOutput($sformatf("v%0d no ades", i), 32'(ades), 32'h0);
        checkOutput($sformatf("v%0d badaddr zero", i), badAddr, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, vecs[i].op, vecs[i].addr, vecs[i].wd, 1'b1, 1'b1, vecs[i].rd, 1'b0);
        #1;
        checkOutput($sformatf("v%0d req data_req", i), 32'(dataReq), 32'h1);
        checkOutput($sformatf("v%0d req data_addr", i), dataAddr, vecs[i].addr);
        checkOutput($sformatf("v%0d req data_wr", i), 32'(dataWr), 32'(vecs[i].expWr));
        checkOutput($sformatf("v%0d req data_size", i), 32'(dataSize), 32'(vecs[i].expSize));
        checkOutput($sformatf("v%0d req data_wstrb", i), 32'(dataWstrb), 32'(vecs[i].expWstrb));
        if (vecs[i].expWr)
          checkOutput($sformatf("v%0d req data_wdata", i), dataWdata, vecs[i].expWdata);
        checkOutput($sformatf("v%0d req stall", i), 32'(stallO), 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        checkOutput($sformatf("v%0d done stall", i), 32'(stallO), 32'h0);
        checkOutput($sformatf("v%0d done bus_err", i), 32'(busErr), 32'h0);
        if (!vecs[i].expWr)
          checkOutput($sformatf("v%0d done readdata", i), readData, vecs[i].expRead);
      end
    end

    // Wait states: addr_ok after 3 idle REQ cycles, data_ok 2 cycles later;
    // a flush during WAIT must not cancel the access.
    @(negedge clk);
    applyStimulus(1'b1, LW, 32'h40C, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("ws idle stall", 32'(stallO), 32'h1);
    checkOutput("ws idle data_req", 32'(dataReq), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("ws req%0d data_req", c), 32'(dataReq), 32'h1);
      checkOutput($sformatf("ws req%0d data_addr", c), dataAddr, 32'h40C);
      checkOutput($sformatf("ws req%0d stall", c), 32'(stallO), 32'h1);
    end
    @(negedge clk);
    dataAddrOk = 1'b1;
    #1;
    checkOutput("ws req3 data_req", 32'(dataReq), 32'h1);
    checkOutput("ws req3 data_addr", dataAddr, 32'h40C);
    @(negedge clk);
    dataAddrOk = 1'b0;
    flushM = 1'b1;
    #1;
    checkOutput("ws wait0 data_req", 32'(dataReq), 32'h0);
    checkOutput("ws wait0 stall", 32'(stallO), 32'h1);
    @(negedge clk);
    dataDataOk = 1'b1;
    dataRdata = 32'h0BADF00D;
    #1;
    checkOutput("ws wait1 data_req", 32'(dataReq), 32'h0);
    checkOutput("ws wait1 stall", 32'(stallO), 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("ws done stall", 32'(stallO), 32'h0);
    checkOutput("ws done readdata", readData, 32'h0BADF00D);
    @(negedge clk);
    #1;
    checkOutput("ws idle after data_req", 32'(dataReq), 32'h0);

    // Timeout instance: one normal load first so stale data is present.
    @(negedge clk);
    memenTo = 1'b1;
    applyStimulus(1'b0, LW, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    dataAddrOk = 1'b1;
    dataDataOk = 1'b1;
    dataRdata = 32'hFFFFFFFF;
    @(negedge clk);
    memenTo = 1'b0;
    dataAddrOk = 1'b0;
    dataDataOk = 1'b0;
    #1;
    checkOutput("to prior readdata", readTo, 32'hFFFFFFFF);

    // No response at all: four bus cycles, then bus_err with zero data.
    @(negedge clk);
    memenTo = 1'b1;
    addrM = 32'h504;
    #1;
    checkOutput("to idle stall", 32'(stallTo), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("to req%0d data_req", c), 32'(reqTo), 32'h1);
      checkOutput($sformatf("to req%0d bus_err", c), 32'(busErrTo), 32'h0);
      checkOutput($sformatf("to req%0d stall", c), 32'(stallTo), 32'h1);
    end
    @(negedge clk);
    memenTo = 1'b0;
    #1;
    checkOutput("to done bus_err", 32'(busErrTo), 32'h1);
    checkOutput("to done readdata", readTo, 32'h0);
    checkOutput("to done stall", 32'(stallTo), 32'h0);
    checkOutput("to done data_req", 32'(reqTo), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("to idle bus_err pulse", 32'(busErrTo), 32'h0);

    // Reset while in WAIT: everything clears, a late data_ok is ignored.
    @(negedge clk);
    memenTo = 1'b1;
    addrM = 32'h600;
    @(negedge clk);
    dataAddrOk = 1'b1;
    @(negedge clk);
    dataAddrOk = 1'b0;
    #1;
    checkOutput("rw wait data_req", 32'(reqTo), 32'h0);
    checkOutput("rw wait stall", 32'(stallTo), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    memenTo = 1'b0;
    dataDataOk = 1'b1;
    dataRdata = 32'h12345678;
    #1;
    checkOutput("rw stall", 32'(stallTo), 32'h0);
    checkOutput("rw data_req", 32'(reqTo), 32'h0);
    checkOutput("rw data_addr", addrTo, 32'h0);
    checkOutput("rw data_size", 32'(sizeTo), 32'h0);
    checkOutput("rw data_wr", 32'(wrTo), 32'h0);
    checkOutput("rw data_wstrb", 32'(wstrbTo), 32'h0);
    checkOutput("rw data_wdata", wdataTo, 32'h0);
    checkOutput("rw readdata", readTo, 32'h0);
    checkOutput("rw bus_err", 32'(busErrTo), 32'h0);
    @(negedge clk);
    dataDataOk = 1'b0;
    #1;
    checkOutput("rw late ok stall", 32'(stallTo), 32'h0);
    checkOutput("rw late ok readdata", readTo, 32'h0);
    checkOutput("rw late ok data_req", 32'(reqTo), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
